// File: rtl/semeion_image_loader.sv
// semeion_image_loader
// Front end for layer_1_complete: gathers one Semeion digit frame (32 pixel
// beats + 1 label beat) from a valid/ready byte stream, launches layer 1
// with a one-cycle load, waits for max_of_10 to finish (or gives up after
// TIMEOUT cycles), then reports the predicted class against the label and
// keeps saturating image / correct-prediction statistics.
module semeion_image_loader #(
  parameter int PIXELS  = 256,
  parameter int BEAT_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [PIXELS-1:0] layer_1_input,
  output logic              load,
  input  logic              done,
  input  logic [3:0]        max,
  output logic              result_valid,
  output logic [3:0]        result_class,
  output logic [3:0]        result_label,
  output logic              result_match,
  output logic              result_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  image_count,
  output logic [CNT_W-1:0]  correct_count
);

  localparam int BEATS   = PIXELS / BEAT_W;
  localparam int BEAT_CW = $clog2(BEATS + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  // The beat counter value at which the incoming beat is the label
  localparam logic [BEAT_CW-1:0] LABEL_BEAT = BEAT_CW'(BEATS);
  // Value of the wait counter during the TIMEOUT-th waiting cycle
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_LOAD,
    ST_WAIT,
    ST_REPORT
  } state_t;

  state_t              state;
  logic [BEAT_CW-1:0]  beat_cnt;
  logic [PIXELS-1:0]   shadow;
  logic [3:0]          label_q;
  logic [TO_W-1:0]     to_cnt;
  logic                done_q;

  logic accept;
  logic last_beat;
  logic done_rise;
  logic give_up;
  logic hit;

  assign accept    = s_valid & s_ready;
  assign last_beat = (beat_cnt == LABEL_BEAT);
  assign done_rise = done & ~done_q;
  assign give_up   = (to_cnt == TO_LAST);
  assign hit       = done_rise & (label_q <= 4'd9) & (max == label_q);

  // Remember last cycle's done so only a genuine low-to-high transition
  // during WAIT counts as completion (a level left high from before is ignored)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Frame collection, layer-1 launch, completion wait and result reporting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_COLLECT;
      beat_cnt       <= '0;
      shadow         <= '0;
      label_q        <= '0;
      to_cnt         <= '0;
      s_ready        <= 1'b0;
      load           <= 1'b0;
      busy           <= 1'b0;
      layer_1_input  <= '0;
      result_valid   <= 1'b0;
      result_class   <= '0;
      result_label   <= '0;
      result_match   <= 1'b0;
      result_timeout <= 1'b0;
      image_count    <= '0;
      correct_count  <= '0;
    end else begin
      load         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_COLLECT: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (accept) begin
            if (last_beat) begin
              label_q       <= s_data[3:0];
              beat_cnt      <= '0;
              layer_1_input <= shadow;
              load          <= 1'b1;
              s_ready       <= 1'b0;
              busy          <= 1'b1;
              state         <= ST_LOAD;
            end else begin
              shadow   <= {shadow[PIXELS-BEAT_W-1:0], s_data};
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise || give_up) begin
            result_valid   <= 1'b1;
            result_timeout <= ~done_rise;
            result_class   <= done_rise ? max : 4'd0;
            result_label   <= label_q;
            result_match   <= hit;
            if (!(&image_count)) begin
              image_count <= image_count + 1'b1;
            end
            if (hit && !(&correct_count)) begin
              correct_count <= correct_count + 1'b1;
            end
            state <= ST_REPORT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_COLLECT;
        end
        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule
